// File: rtl/vibrometer_axis_pkg.sv
// Shared definitions for the vibrometer AXIS rate-change blocks
// (axis_throttler / axis_expander).
package vibrometer_axis_pkg;

    // Width of the log_* rate exponent ports.
    localparam int LOG_W = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Repeat limit for a given exponent: 2^min(log_val, cnt_width-1) - 1.
    // The clamp keeps the limit representable, so the repeat counter never wraps.
    function automatic logic [63:0] clamp_limit(input logic [LOG_W-1:0] log_val,
                                                input int               cnt_width);
        int exp_v;
        exp_v = (int'(log_val) >= cnt_width) ? (cnt_width - 1) : int'(log_val);
        return (64'd1 << exp_v) - 64'd1;
    endfunction

endpackage

// File: rtl/axis_expander.sv
// Zero-order-hold interpolator: every accepted input beat is re-emitted
// 2^log_expand times on the master side, with tlast on the final repeat.
// A new sample may be accepted in the same cycle the last repeat transfers,
// so a continuous input stream produces a continuous output stream.
//
// state | meaning
// EMPTY | no sample held, input side ready
// HOLD  | sample held, emitting repeats
module axis_expander
    import vibrometer_axis_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [LOG_W-1:0]            log_expand,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tlast
);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [AXIS_TDATA_WIDTH-1:0]   r_data;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic [CNT_WIDTH-1:0]          r_limit;
    logic [CNT_WIDTH-1:0]          w_limit_new;
    logic                          w_at_limit;
    logic                          w_m_xfer;
    logic                          w_s_accept;

    assign w_limit_new   = CNT_WIDTH'(clamp_limit(log_expand, CNT_WIDTH));
    assign w_at_limit    = (r_cnt == r_limit);
    assign M_AXIS_tvalid = (r_state == HOLD);
    assign M_AXIS_tdata  = r_data;
    assign M_AXIS_tlast  = M_AXIS_tvalid && w_at_limit;
    assign w_m_xfer      = M_AXIS_tvalid && M_AXIS_tready;
    // Gated by aresetn so the input side is never ready while held in reset.
    assign S_AXIS_tready = aresetn && ((r_state == EMPTY) || (w_m_xfer && w_at_limit));
    assign w_s_accept    = S_AXIS_tvalid && S_AXIS_tready;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter HOLD on accept, leave only after the last repeat
    // transfers with no replacement sample arriving.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_s_accept) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_m_xfer && w_at_limit && !w_s_accept) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Sample, repeat counter and limit: reload on accept, count on each
    // non-final output transfer, otherwise hold.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_limit <= '0;
        end else if (w_s_accept) begin
            r_data  <= S_AXIS_tdata;
            r_cnt   <= '0;
            r_limit <= w_limit_new;
        end else if (w_m_xfer && !w_at_limit) begin
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_expander.sv
// Bench for axis_expander. A queue holds every output beat still owed
// (data, last-flag); it is filled with N copies on each input accept and
// drained on each output transfer.
module tb_axis_expander;

    localparam int DW = 32;
    localparam int CW = 4;   // small counter so exponents >= 4 clamp to N=8

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [4:0]    log_expand;
    logic [DW-1:0] S_AXIS_tdata;
    logic          S_AXIS_tvalid;
    logic          S_AXIS_tready;
    logic [DW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready;
    logic          M_AXIS_tlast;

    axis_expander #(.AXIS_TDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .log_expand    (log_expand),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    sink_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random
    int    out_count = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int repeats(input logic [4:0] lg);
        int e;
        e = (int'(lg) > CW - 1) ? CW - 1 : int'(lg);
        return 2 ** e;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge aclk) begin
        logic exp_valid;
        logic exp_rdy;
        int   n;
        if (!aresetn) begin
            exp_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0);
            chk("m_tvalid", {31'd0, M_AXIS_tvalid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("m_tdata", M_AXIS_tdata, exp_q[0].d);
                chk("m_tlast", {31'd0, M_AXIS_tlast}, {31'd0, exp_q[0].last});
                exp_rdy = M_AXIS_tready && exp_q[0].last;
            end else begin
                exp_rdy = 1'b1;
            end
            chk("s_tready", {31'd0, S_AXIS_tready}, {31'd0, exp_rdy});
            if (exp_valid && M_AXIS_tready) begin
                void'(exp_q.pop_front());
                out_count++;
            end
            if (S_AXIS_tvalid && exp_rdy) begin
                n = repeats(log_expand);
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back('{d: S_AXIS_tdata, last: (k == n - 1)});
                end
            end
        end
    end

    // Sink ready generator.
    always @(posedge aclk) begin
        int ph;
        #1;
        case (sink_mode)
            0: M_AXIS_tready = 1'b1;
            1: begin
                ph = (ph + 1) % 4;
                M_AXIS_tready = (ph == 0) || (ph == 3);
            end
            default: M_AXIS_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [DW-1:0] d, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(posedge aclk);
            #1;
        end
        S_AXIS_tdata  = d;
        S_AXIS_tvalid = 1'b1;
        guard = 0;
        @(negedge aclk);
        while (!S_AXIS_tready && guard < 500) begin
            guard++;
            @(negedge aclk);
        end
        if (guard >= 500) begin
            chk("send_timeout", 32'd1, 32'd0);
        end
        @(posedge aclk);
        #1;
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || M_AXIS_tvalid) && guard < 2000) begin
            guard++;
            @(posedge aclk);
            #1;
        end
        chk(tag, exp_q.size(), 0);
        @(posedge aclk);
        #1;
        chk({tag, "_idle"}, {31'd0, M_AXIS_tvalid}, 32'd0);
    endtask

    initial begin
        int base;
        aresetn       = 1'b0;
        log_expand    = 5'd0;
        S_AXIS_tdata  = '0;
        S_AXIS_tvalid = 1'b0;
        M_AXIS_tready = 1'b1;
        #2;
        chk("rst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("rst_tdata",  M_AXIS_tdata, 32'd0);
        chk("rst_tlast",  {31'd0, M_AXIS_tlast}, 32'd0);
        chk("rst_sready", {31'd0, S_AXIS_tready}, 32'd0);
        #20;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Basic repeat: one beat of 2, N=8.
        sink_mode = 0; log_expand = 5'd3;
        base = out_count;
        send(32'd2, 1);
        drain("basic_drain");
        chk("basic_count", out_count - base, 8);

        // Back-to-back 5,6,7 with N=4.
        log_expand = 5'd2;
        base = out_count;
        send(32'd5, 0); send(32'd6, 0); send(32'd7, 0);
        drain("b2b_drain");
        chk("b2b_count", out_count - base, 12);

        // Backpressure with N=2.
        sink_mode = 1; log_expand = 5'd1;
        base = out_count;
        for (int i = 0; i < 4; i++) send(32'h100 + i, 0);
        drain("bp_drain");
        chk("bp_count", out_count - base, 8);

        // Exponent change mid-sample: 9 keeps N=8, next is N=1.
        sink_mode = 0; log_expand = 5'd3;
        base = out_count;
        send(32'd9, 0);
        repeat (4) @(posedge aclk);
        #1;
        log_expand = 5'd0;
        send(32'd10, 0);
        drain("chg_drain");
        chk("chg_count", out_count - base, 9);

        // Pass-through 1..10 with random gaps.
        base = out_count;
        for (int i = 1; i <= 10; i++) send(i, $urandom_range(0, 3));
        drain("pt_drain");
        chk("pt_count", out_count - base, 10);

        // Clamp: exponent 31 with CNT_WIDTH=4 gives N=8.
        log_expand = 5'd31;
        base = out_count;
        send(32'hC1A, 0);
        drain("clamp_drain");
        chk("clamp_count", out_count - base, 8);

        // Async reset mid-HOLD, between clock edges.
        log_expand = 5'd3;
        send(32'hDEAD, 0);
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("arst_sready", {31'd0, S_AXIS_tready}, 32'd0);
        chk("arst_tdata",  M_AXIS_tdata, 32'd0);
        chk("arst_tlast",  {31'd0, M_AXIS_tlast}, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        base = out_count;
        send(32'hBEEF, 1);
        drain("arst_drain");
        chk("arst_count", out_count - base, 8);

        // Random traffic, random sink, exponents 0..5 (4,5 clamp).
        sink_mode = 2;
        for (int i = 0; i < 40; i++) begin
            log_expand = 5'($urandom_range(0, 5));
            send($urandom, $urandom_range(0, 2));
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
